viterbi_channel_inj: RTL and testbench

- Configurable noisy-channel stage between the rate-1/2 convolutional encoder and the Viterbi decoder.
- Registers each 2-bit encoder symbol and, on pseudo-random or forced triggers, flips one or both bits, either singly or as a burst over consecutive symbols.
- Keeps saturating symbol and bit-error counters so benches can report the actual channel bit error rate.
- Fully deterministic for a given seed, so decoder regressions are reproducible.

---
 rtl/viterbi_pkg.sv | 38 +++
 rtl/viterbi_channel_inj_if.sv | 17 +
 rtl/chan_lfsr32.sv | 22 ++
 rtl/viterbi_channel_inj.sv | 170 +++++++++++++++++
 tb/tb_viterbi_channel_inj.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared types, constants and small helpers for the noisy-channel stage.
package viterbi_pkg;

    typedef logic [1:0] sym_t;

    typedef enum logic [1:0] {
        CH_OFF   = 2'd0,
        CH_FLIP1 = 2'd1,
        CH_FLIP2 = 2'd2,
        CH_BURST = 2'd3
    } chan_mode_e;

    typedef enum logic {
        CLEAN = 1'b0,
        BURST = 1'b1
    } chan_state_e;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // One Galois step: shift right, fold taps back in when bit 0 falls out
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = {1'b0, cur[31:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // Number of flipped bits in a 2-bit error mask
    function automatic logic [1:0] popcount2(input sym_t m);
        return {1'b0, m[1]} + {1'b0, m[0]};
    endfunction

endpackage

// File: rtl/viterbi_channel_inj_if.sv
// Symbol stream into and out of the channel stage.
interface viterbi_channel_inj_if;
    import viterbi_pkg::*;

    logic valid_i;
    sym_t sym_i;
    logic valid_o;
    sym_t sym_o;
    sym_t err_o;

    // Encoder / stimulus side
    modport master (output valid_i, output sym_i,
                    input  valid_o, input  sym_o, input err_o);
    // Channel stage side
    modport slave  (input  valid_i, input  sym_i,
                    output valid_o, output sym_o, output err_o);
endinterface

// File: rtl/chan_lfsr32.sv
// 32-bit Galois LFSR that advances only when enabled; reusable by stimulus generators.
module chan_lfsr32 #(
    parameter logic [31:0] SEED = 32'hACE1_1234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [31:0] state
);
    import viterbi_pkg::*;

    // Load seed on reset, step once per enabled cycle, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (adv) begin
            state <= lfsr_next(state);
        end else begin
            state <= state;
        end
    end
endmodule

// File: rtl/viterbi_channel_inj.sv
// Noisy-channel stage: registers encoder symbols, flips bits on random or
// forced triggers (single or burst) and keeps saturating error statistics.
module viterbi_channel_inj
    import viterbi_pkg::*;
#(
    parameter int          N         = 4,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_1234,
    parameter int          BL_W      = 3,
    parameter int          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    viterbi_channel_inj_if.slave bus,
    input  logic [1:0]           mode_i,
    input  logic [BL_W-1:0]      burst_len_i,
    input  logic                 inject_now_i,
    input  logic                 clear_i,
    output logic [CNT_W-1:0]     sym_ct_o,
    output logic [CNT_W-1:0]     bit_err_ct_o,
    output logic                 sat_o
);

    // Mask of the LFSR bits that must all be ones for a random trigger
    localparam logic [31:0]      LOW_MASK    = (32'h1 << N) - 32'h1;
    localparam logic [BL_W-1:0]  REM_ONE     = BL_W'(1'b1);
    localparam logic [BL_W-1:0]  REM_ZERO    = {BL_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   CNT_MAX_EXT = {1'b0, {CNT_W{1'b1}}};

    logic [31:0]      lfsr_s;
    logic             trig_s;
    chan_mode_e       mode_s;
    sym_t             err_s;
    chan_state_e      state_r, state_nx_s;
    logic [BL_W-1:0]  rem_r, rem_nx_s;
    logic [CNT_W:0]   sym_sum_s, bit_sum_s;
    logic [CNT_W-1:0] sym_ct_r, bit_ct_r;
    logic             sat_r, sat_hit_s;
    logic             valid_r;
    sym_t             sym_r, err_r;

    chan_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv   (bus.valid_i),
        .state (lfsr_s)
    );

    // Trigger looks at the pre-shift LFSR value; bits above N are masked to ones
    assign trig_s = bus.valid_i & ((&(lfsr_s | ~LOW_MASK)) | inject_now_i);
    assign mode_s = chan_mode_e'(mode_i);

    // Error mask and next burst state for the symbol presented this cycle
    always_comb begin
        err_s      = 2'b00;
        state_nx_s = state_r;
        rem_nx_s   = rem_r;
        if (bus.valid_i) begin
            if ((state_r == BURST) && (mode_s == CH_BURST)) begin
                // Inside a burst: triggers neither restart nor extend it
                err_s    = 2'b10;
                rem_nx_s = rem_r - REM_ONE;
                if (rem_r == REM_ONE) begin
                    state_nx_s = CLEAN;
                end else begin
                    state_nx_s = BURST;
                end
            end else begin
                // CLEAN, or a burst aborted by a mode change
                state_nx_s = CLEAN;
                rem_nx_s   = REM_ZERO;
                case (mode_s)
                    CH_OFF: begin
                        err_s = 2'b00;
                    end
                    CH_FLIP1: begin
                        if (trig_s) begin
                            err_s = 2'b10;
                        end else begin
                            err_s = 2'b00;
                        end
                    end
                    CH_FLIP2: begin
                        if (trig_s) begin
                            err_s = 2'b11;
                        end else begin
                            err_s = 2'b00;
                        end
                    end
                    CH_BURST: begin
                        if (trig_s) begin
                            err_s = 2'b10;
                            // Length 0 and 1 both mean a single-symbol hit
                            if (burst_len_i > REM_ONE) begin
                                rem_nx_s   = burst_len_i - REM_ONE;
                                state_nx_s = BURST;
                            end else begin
                                rem_nx_s   = REM_ZERO;
                                state_nx_s = CLEAN;
                            end
                        end else begin
                            err_s = 2'b00;
                        end
                    end
                    default: begin
                        err_s = 2'b00;
                    end
                endcase
            end
        end else begin
            // Idle cycle: burst position is held
            err_s      = 2'b00;
            state_nx_s = state_r;
            rem_nx_s   = rem_r;
        end
    end

    // Saturating counter candidates with one guard bit to detect the ceiling
    always_comb begin
        sym_sum_s = {1'b0, sym_ct_r} + (CNT_W+1)'(1'b1);
        bit_sum_s = {1'b0, bit_ct_r} + (CNT_W+1)'(popcount2(err_s));
        sat_hit_s = (sym_sum_s >= CNT_MAX_EXT) | (bit_sum_s >= CNT_MAX_EXT);
    end

    // Output register, burst FSM and statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r  <= 1'b0;
            sym_r    <= 2'b00;
            err_r    <= 2'b00;
            state_r  <= CLEAN;
            rem_r    <= REM_ZERO;
            sym_ct_r <= {CNT_W{1'b0}};
            bit_ct_r <= {CNT_W{1'b0}};
            sat_r    <= 1'b0;
        end else begin
            valid_r <= bus.valid_i;
            err_r   <= err_s;
            if (bus.valid_i) begin
                sym_r <= bus.sym_i ^ err_s;
            end else begin
                sym_r <= 2'b00;
            end
            state_r <= state_nx_s;
            rem_r   <= rem_nx_s;
            // Clear wins over a coincident valid symbol
            if (clear_i) begin
                sym_ct_r <= {CNT_W{1'b0}};
                bit_ct_r <= {CNT_W{1'b0}};
                sat_r    <= 1'b0;
            end else if (bus.valid_i) begin
                sym_ct_r <= (sym_sum_s > CNT_MAX_EXT) ? CNT_MAX : sym_sum_s[CNT_W-1:0];
                bit_ct_r <= (bit_sum_s > CNT_MAX_EXT) ? CNT_MAX : bit_sum_s[CNT_W-1:0];
                sat_r    <= sat_r | sat_hit_s;
            end else begin
                sym_ct_r <= sym_ct_r;
                bit_ct_r <= bit_ct_r;
                sat_r    <= sat_r;
            end
        end
    end

    assign bus.valid_o   = valid_r;
    assign bus.sym_o     = sym_r;
    assign bus.err_o     = err_r;
    assign sym_ct_o      = sym_ct_r;
    assign bit_err_ct_o  = bit_ct_r;
    assign sat_o         = sat_r;

endmodule

// File: tb/tb_viterbi_channel_inj.sv
// Directed bench for viterbi_channel_inj with a reference LFSR model.
module tb_viterbi_channel_inj;
    import viterbi_pkg::*;

    localparam logic [31:0] SEED = 32'hACE1_1234;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [2:0]  blen;
    logic        inj;
    logic        clr;
    logic [15:0] sym_ct, bit_ct;
    logic        sat;

    logic        clr2;
    logic [3:0]  sym_ct2, bit_ct2;
    logic        sat2;

    int n_pass;
    int n_total;

    logic [31:0] m_lfsr;
    logic        m_rnd;
    logic        rec [4096];

    viterbi_channel_inj_if bus ();
    viterbi_channel_inj_if bus2 ();

    viterbi_channel_inj #(.N(4), .LFSR_SEED(SEED), .BL_W(3), .CNT_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mode_i       (mode),
        .burst_len_i  (blen),
        .inject_now_i (inj),
        .clear_i      (clr),
        .sym_ct_o     (sym_ct),
        .bit_err_ct_o (bit_ct),
        .sat_o        (sat)
    );

    viterbi_channel_inj #(.N(4), .LFSR_SEED(SEED), .BL_W(3), .CNT_W(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus2),
        .mode_i       (2'b00),
        .burst_len_i  (3'd0),
        .inject_now_i (1'b0),
        .clear_i      (clr2),
        .sym_ct_o     (sym_ct2),
        .bit_err_ct_o (bit_ct2),
        .sat_o        (sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_next(input logic [31:0] s);
        logic [31:0] tmp;
        tmp = s >> 1;
        if (s[0]) tmp = tmp ^ TAPS;
        return tmp;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock; m_rnd reports whether the model predicts a random trigger this cycle
    task automatic tick();
        logic r;
        logic v;
        r = rst;
        v = bus.valid_i;
        m_rnd = (m_lfsr[3:0] == 4'hF);
        @(posedge clk);
        #1;
        if (r) m_lfsr = SEED;
        else if (v) m_lfsr = ref_next(m_lfsr);
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] m, input logic i);
        bus.valid_i = v;
        bus.sym_i   = s;
        mode        = m;
        inj         = i;
    endtask

    initial begin
        int cnt_exp;
        int mism;
        n_pass = 0;
        n_total = 0;
        m_lfsr = SEED;
        m_rnd = 1'b0;
        rst = 1'b1;
        clr = 1'b0;
        clr2 = 1'b0;
        blen = 3'd0;
        drive(1'b0, 2'b00, 2'b00, 1'b0);
        bus2.valid_i = 1'b0;
        bus2.sym_i = 2'b00;

        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_sym", 32'(bus.sym_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_symct", 32'(sym_ct), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        rst = 1'b0;

        // Test 1: mode off, symbols pass unchanged
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'(i % 4), 2'b00, 1'b0);
            tick();
            check("t1_sym", 32'(bus.sym_o), 32'(i % 4));
            check("t1_err", 32'(bus.err_o), 32'd0);
        end
        check("t1_valid", 32'(bus.valid_o), 32'd1);
        check("t1_symct", 32'(sym_ct), 32'd20);
        check("t1_bitct", 32'(bit_ct), 32'd0);

        // Test 2a: single flip of bit1 on symbol 5
        for (int i = 0; i < 8; i++) begin
            if (i == 5) drive(1'b1, 2'b01, 2'b01, 1'b1);
            else        drive(1'b1, 2'b00, 2'b00, 1'b0);
            tick();
            check("t2a_err", 32'(bus.err_o), (i == 5) ? 32'd2 : 32'd0);
            check("t2a_sym", 32'(bus.sym_o), (i == 5) ? 32'd3 : 32'd0);
        end
        check("t2a_bitct", 32'(bit_ct), 32'd1);

        // Idle clear, then Test 2b: flip both bits
        drive(1'b0, 2'b11, 2'b00, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_symct", 32'(sym_ct), 32'd0);
        check("idle_sym", 32'(bus.sym_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 5) drive(1'b1, 2'b01, 2'b10, 1'b1);
            else        drive(1'b1, 2'b00, 2'b00, 1'b0);
            tick();
            check("t2b_err", 32'(bus.err_o), (i == 5) ? 32'd3 : 32'd0);
            check("t2b_sym", 32'(bus.sym_o), (i == 5) ? 32'd2 : 32'd0);
        end
        check("t2b_bitct", 32'(bit_ct), 32'd2);

        // Test 3: burst of 3 with a 2-cycle gap and an ignored re-inject
        drive(1'b0, 2'b00, 2'b00, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        blen = 3'd3;
        drive(1'b1, 2'b00, 2'b00, 1'b0); tick();
        check("t3_s0", 32'(bus.err_o), 32'd0);
        drive(1'b1, 2'b00, 2'b00, 1'b0); tick();
        check("t3_s1", 32'(bus.err_o), 32'd0);
        drive(1'b1, 2'b00, 2'b11, 1'b1); tick();
        check("t3_s2", 32'(bus.err_o), 32'd2);
        check("t3_s2_sym", 32'(bus.sym_o), 32'd2);
        drive(1'b1, 2'b00, 2'b11, 1'b1); tick();
        check("t3_s3", 32'(bus.err_o), 32'd2);
        drive(1'b0, 2'b11, 2'b11, 1'b0); tick();
        check("t3_gap_valid", 32'(bus.valid_o), 32'd0);
        check("t3_gap_err", 32'(bus.err_o), 32'd0);
        check("t3_gap_sym", 32'(bus.sym_o), 32'd0);
        drive(1'b0, 2'b11, 2'b11, 1'b0); tick();
        drive(1'b1, 2'b00, 2'b11, 1'b0); tick();
        check("t3_s4", 32'(bus.err_o), 32'd2);
        check("t3_bitct", 32'(bit_ct), 32'd3);
        drive(1'b1, 2'b00, 2'b11, 1'b0); tick();
        check("t3_s5", 32'(bus.err_o), m_rnd ? 32'd2 : 32'd0);
        drive(1'b0, 2'b00, 2'b00, 1'b0);

        // Test 4: random flips at 1/16 against the reference LFSR, then rerun
        rst = 1'b1; tick(); rst = 1'b0;
        cnt_exp = 0;
        mism = 0;
        for (int i = 0; i < 4096; i++) begin
            drive(1'b1, 2'b00, 2'b01, 1'b0);
            tick();
            rec[i] = bus.err_o[1];
            if (m_rnd) cnt_exp++;
            if (bus.err_o !== (m_rnd ? 2'b10 : 2'b00)) mism++;
        end
        check("t4_model_mism", 32'(mism), 32'd0);
        check("t4_bitct", 32'(bit_ct), 32'(cnt_exp));
        check("t4_range", 32'((bit_ct >= 16'd200) && (bit_ct <= 16'd320)), 32'd1);
        check("t4_symct", 32'(sym_ct), 32'd4096);
        drive(1'b0, 2'b00, 2'b00, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        mism = 0;
        for (int i = 0; i < 4096; i++) begin
            drive(1'b1, 2'b00, 2'b01, 1'b0);
            tick();
            if (bus.err_o[1] !== rec[i]) mism++;
        end
        check("t4_repeat", 32'(mism), 32'd0);
        drive(1'b0, 2'b00, 2'b00, 1'b0);

        // Test 5: reset in the middle of a 5-symbol burst
        rst = 1'b1; tick(); rst = 1'b0;
        blen = 3'd5;
        drive(1'b1, 2'b00, 2'b11, 1'b1); tick();
        check("t5_b0", 32'(bus.err_o), 32'd2);
        drive(1'b1, 2'b00, 2'b11, 1'b0); tick();
        check("t5_b1", 32'(bus.err_o), 32'd2);
        drive(1'b0, 2'b00, 2'b11, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_valid", 32'(bus.valid_o), 32'd0);
        check("t5_err", 32'(bus.err_o), 32'd0);
        check("t5_bitct", 32'(bit_ct), 32'd0);
        check("t5_state", 32'(u_dut.state_r), 32'(CLEAN));
        check("t5_lfsr", u_dut.u_lfsr.state, SEED);
        drive(1'b1, 2'b01, 2'b11, 1'b0); tick();
        check("t5_post_err", 32'(bus.err_o), m_rnd ? 32'd2 : 32'd0);
        check("t5_post_sym", 32'(bus.sym_o), m_rnd ? 32'd3 : 32'd1);
        drive(1'b0, 2'b00, 2'b00, 1'b0);

        // Test 6: 4-bit counters saturate, clear wins over a coincident symbol
        for (int i = 0; i < 20; i++) begin
            bus2.valid_i = 1'b1;
            bus2.sym_i = 2'(i % 4);
            tick();
            if (i == 13) begin
                check("t6_ct14", 32'(sym_ct2), 32'd14);
                check("t6_sat14", 32'(sat2), 32'd0);
            end
            if (i == 14) check("t6_sat15", 32'(sat2), 32'd1);
        end
        check("t6_ct_sat", 32'(sym_ct2), 32'd15);
        check("t6_sat", 32'(sat2), 32'd1);
        check("t6_bitct", 32'(bit_ct2), 32'd0);
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        check("t6_clr_ct", 32'(sym_ct2), 32'd0);
        check("t6_clr_sat", 32'(sat2), 32'd0);
        tick();
        check("t6_after", 32'(sym_ct2), 32'd1);
        bus2.valid_i = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
